// File: rtl/ahb_irq_pkg.sv
// Shared constants for the AHB interrupt aggregator: register offsets and ID sizing.
package ahb_irq_pkg;

  localparam int ID_W    = 5;
  localparam int MAX_SRC = 32;

  localparam logic [4:0] OFF_PEND   = 5'h00;
  localparam logic [4:0] OFF_ENABLE = 5'h04;
  localparam logic [4:0] OFF_MODE   = 5'h08;
  localparam logic [4:0] OFF_CLEAR  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_SWSET  = 5'h14;

endpackage

// File: rtl/ahb_irq_ctrl_prio_enc.sv
// Fixed-priority encoder over the masked pending vector; the lowest index wins.
module irq_prio_enc
  import ahb_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  // Scan from the top down so the last hit, the lowest index, is the one kept.
  always_comb begin
    any = |req;
    idx = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/ahb_irq_ctrl.sv
// AHB-Lite interrupt aggregator: per-source pending/enable/mode with one registered vectored request.
module ahb_irq_ctrl
  import ahb_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HSEL,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic [N_SRC-1:0]  irq_in,
  output logic              irq_out,
  output logic [ID_W-1:0]   irq_id
);

  logic [4:0]       last_addr_r;
  logic             last_write_r;
  logic [N_SRC-1:0] pend_r;
  logic [N_SRC-1:0] enable_r;
  logic [N_SRC-1:0] mode_r;
  logic [N_SRC-1:0] irq_prev_r;
  logic             irq_out_r;
  logic [ID_W-1:0]  irq_id_r;

  logic             wr_en_s;
  logic [N_SRC-1:0] sw_set_s;
  logic [N_SRC-1:0] clr_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] pend_next_s;
  logic             any_s;
  logic [ID_W-1:0]  idx_s;
  logic             unused_s;

  function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
    logic [31:0] w;
    w = 32'd0;
    w[N_SRC-1:0] = v;
    return w;
  endfunction

  assign HREADYOUT = 1'b1;
  assign irq_out   = irq_out_r;
  assign irq_id    = irq_id_r;
  assign unused_s  = ^{HADDR[31:5], HTRANS[0], HWDATA};

  // Address-phase capture; deliberately unreset, it is only ever used qualified.
  always_ff @(posedge HCLK) begin
    if (HREADY) begin
      last_addr_r  <= HADDR[4:0];
      last_write_r <= HSEL & HWRITE & HTRANS[1];
    end
  end

  // Write strobes; a stalled data phase only completes once HREADY returns high.
  always_comb begin
    wr_en_s = last_write_r & HREADY;
    if (wr_en_s && (last_addr_r == OFF_SWSET)) begin
      sw_set_s = HWDATA[N_SRC-1:0];
    end else begin
      sw_set_s = {N_SRC{1'b0}};
    end
    if (wr_en_s && (last_addr_r == OFF_CLEAR)) begin
      clr_s = HWDATA[N_SRC-1:0];
    end else begin
      clr_s = {N_SRC{1'b0}};
    end
    // Edge sources: set beats clear. Level sources simply follow the line.
    set_s       = (irq_in & ~irq_prev_r) | sw_set_s;
    pend_next_s = (mode_r & ((pend_r & ~clr_s) | set_s)) | (~mode_r & irq_in);
  end

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req (pend_r & enable_r),
    .any (any_s),
    .idx (idx_s)
  );

  // Interrupt state and control registers; reset dominates any concurrent write.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_r     <= {N_SRC{1'b0}};
      enable_r   <= {N_SRC{1'b0}};
      mode_r     <= {N_SRC{1'b0}};
      irq_prev_r <= {N_SRC{1'b0}};
      irq_out_r  <= 1'b0;
      irq_id_r   <= {ID_W{1'b0}};
    end else begin
      pend_r     <= pend_next_s;
      irq_prev_r <= irq_in;
      irq_out_r  <= any_s;
      irq_id_r   <= idx_s;
      if (wr_en_s && (last_addr_r == OFF_ENABLE)) begin
        enable_r <= HWDATA[N_SRC-1:0];
      end
      if (wr_en_s && (last_addr_r == OFF_MODE)) begin
        mode_r <= HWDATA[N_SRC-1:0];
      end
    end
  end

  // Read mux works from the captured address and the live register contents.
  always_comb begin
    case (last_addr_r)
      OFF_PEND:   HRDATA = zext(pend_r);
      OFF_ENABLE: HRDATA = zext(enable_r);
      OFF_MODE:   HRDATA = zext(mode_r);
      OFF_STATUS: HRDATA = {irq_out_r, 26'd0, irq_id_r};
      default:    HRDATA = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ahb_irq_ctrl.sv
// Bench for ahb_irq_ctrl: directed scenarios plus randomized bus/irq traffic against a per-source reference model.
module tb_ahb_irq_ctrl;
  import ahb_irq_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [N-1:0] irq_in;
  logic        irq_out;
  logic [4:0]  irq_id;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;

  // Reference model state, one entry per source.
  bit         m_pend [N];
  bit         m_en   [N];
  bit         m_mode [N];
  bit         m_prev [N];
  bit         m_out;
  int         m_id;
  logic [4:0] m_addr;
  bit         m_wr;

  always #5 clk = ~clk;

  ahb_irq_ctrl #(.N_SRC(N)) dut (
    .HCLK      (clk),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .irq_in    (irq_in),
    .irq_out   (irq_out),
    .irq_id    (irq_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read();
    logic [31:0] w;
    w = 32'd0;
    if (m_addr == OFF_PEND) begin
      for (int i = 0; i < N; i++) w[i] = m_pend[i];
    end else if (m_addr == OFF_ENABLE) begin
      for (int i = 0; i < N; i++) w[i] = m_en[i];
    end else if (m_addr == OFF_MODE) begin
      for (int i = 0; i < N; i++) w[i] = m_mode[i];
    end else if (m_addr == OFF_STATUS) begin
      w = {m_out, 26'd0, 5'(m_id)};
    end
    return w;
  endfunction

  // Reference model: evaluated once per rising edge from the inputs held over the past cycle.
  initial begin
    forever begin
      bit wr;
      bit nout;
      int nid;
      @(posedge clk);
      wr = m_wr && HREADY;
      if (!HRESETn) begin
        for (int i = 0; i < N; i++) begin
          m_pend[i] = 1'b0; m_en[i] = 1'b0; m_mode[i] = 1'b0; m_prev[i] = 1'b0;
        end
        m_out = 1'b0;
        m_id  = 0;
      end else begin
        nout = 1'b0;
        nid  = 0;
        for (int i = 0; i < N; i++) begin
          if (m_pend[i] && m_en[i] && !nout) begin
            nout = 1'b1;
            nid  = i;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (m_mode[i]) begin
            if ((irq_in[i] && !m_prev[i]) || (wr && m_addr == OFF_SWSET && HWDATA[i]))
              m_pend[i] = 1'b1;
            else if (wr && m_addr == OFF_CLEAR && HWDATA[i])
              m_pend[i] = 1'b0;
          end else begin
            m_pend[i] = irq_in[i];
          end
          m_prev[i] = irq_in[i];
          if (wr && m_addr == OFF_ENABLE) m_en[i] = HWDATA[i];
          if (wr && m_addr == OFF_MODE)   m_mode[i] = HWDATA[i];
        end
        m_out = nout;
        m_id  = nid;
      end
      if (HREADY) begin
        m_addr = HADDR[4:0];
        m_wr   = HSEL && HWRITE && HTRANS[1];
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_eq("model_irq_out", 32'(irq_out), 32'(m_out));
        check_eq("model_irq_id", 32'(irq_id), 32'(m_id));
        check_eq("model_hrdata", HRDATA, m_read());
        check_eq("hreadyout", 32'(HREADYOUT), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HWRITE = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'd0;
  endtask

  task automatic addr_phase(input logic [4:0] a, input logic wr);
    HSEL   = 1'b1;
    HWRITE = wr;
    HTRANS = 2'b10;
    HADDR  = {27'd0, a};
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    tick(1);
    idle_bus();
    HWDATA = d;
    tick(1);
  endtask

  task automatic bus_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr_phase(a, 1'b0);
    tick(1);
    idle_bus();
    check_eq(tag, HRDATA, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    HRESETn = 1'b0;
    idle_bus();
    HWDATA = 32'd0;
    HREADY = 1'b1;
    irq_in = '0;
    tick(3);
    HRESETn = 1'b1;
    chk_en  = 1'b1;

    // Reset state: every offset reads zero, no request.
    for (int a = 0; a < 32; a += 4) bus_read("rst_read", 5'(a), 32'd0);
    check_eq("rst_irq_out", 32'(irq_out), 32'd0);
    check_eq("rst_irq_id", 32'(irq_id), 32'd0);

    // Level mode: 3-cycle pulse on source 0, CLEAR mid-pulse ignored.
    bus_write(OFF_ENABLE, 32'h01);
    irq_in[0] = 1'b1;
    addr_phase(OFF_CLEAR, 1'b1);
    tick(1);
    check_eq("lvl_e1_out", 32'(irq_out), 32'd0);
    idle_bus();
    HWDATA = 32'h01;
    tick(1);
    check_eq("lvl_e2_out", 32'(irq_out), 32'd1);
    check_eq("lvl_e2_id", 32'(irq_id), 32'd0);
    tick(1);
    check_eq("lvl_e3_out", 32'(irq_out), 32'd1);
    irq_in[0] = 1'b0;
    tick(1);
    check_eq("lvl_e4_out", 32'(irq_out), 32'd1);
    tick(1);
    check_eq("lvl_e5_out", 32'(irq_out), 32'd0);

    // Edge mode on sources 2 and 5.
    bus_write(OFF_MODE, 32'h24);
    bus_write(OFF_ENABLE, 32'h24);
    irq_in = 8'h24;
    tick(1);
    irq_in = 8'h00;
    check_eq("edge_e1_out", 32'(irq_out), 32'd0);
    tick(1);
    check_eq("edge_out", 32'(irq_out), 32'd1);
    check_eq("edge_id2", 32'(irq_id), 32'd2);
    bus_write(OFF_CLEAR, 32'h04);
    tick(1);
    check_eq("edge_id5", 32'(irq_id), 32'd5);
    bus_write(OFF_CLEAR, 32'h20);
    check_eq("edge_clr_lag", 32'(irq_out), 32'd1);
    tick(1);
    check_eq("edge_clr_out", 32'(irq_out), 32'd0);
    check_eq("edge_clr_id", 32'(irq_id), 32'd0);

    // Rising edge and CLEAR on source 3 in the same cycle: set wins.
    bus_write(OFF_MODE, 32'h2C);
    addr_phase(OFF_CLEAR, 1'b1);
    tick(1);
    idle_bus();
    HWDATA = 32'h08;
    irq_in = 8'h08;
    tick(1);
    irq_in = 8'h00;
    bus_read("setwins_pend", OFF_PEND, 32'h08);
    bus_write(OFF_CLEAR, 32'h08);
    bus_read("setwins_clr", OFF_PEND, 32'h00);

    // Software set while masked, then unmask.
    bus_write(OFF_ENABLE, 32'h00);
    bus_write(OFF_MODE, 32'h80);
    bus_write(OFF_SWSET, 32'h80);
    bus_read("swset_pend", OFF_PEND, 32'h80);
    check_eq("swset_masked", 32'(irq_out), 32'd0);
    bus_write(OFF_ENABLE, 32'h80);
    tick(1);
    check_eq("swset_out", 32'(irq_out), 32'd1);
    check_eq("swset_id", 32'(irq_id), 32'd7);
    bus_read("swset_status", OFF_STATUS, 32'h8000_0007);

    // Reset while everything is pending, with a write completing on the reset edge.
    bus_write(OFF_MODE, 32'hFF);
    bus_write(OFF_SWSET, 32'hFF);
    bus_write(OFF_ENABLE, 32'hFF);
    tick(1);
    bus_read("prerst_pend", OFF_PEND, 32'hFF);
    check_eq("prerst_out", 32'(irq_out), 32'd1);
    addr_phase(OFF_ENABLE, 1'b1);
    tick(1);
    idle_bus();
    HWDATA  = 32'h5A;
    HRESETn = 1'b0;
    tick(1);
    HRESETn = 1'b1;
    check_eq("rst2_out", 32'(irq_out), 32'd0);
    check_eq("rst2_id", 32'(irq_id), 32'd0);
    bus_read("rst2_pend", OFF_PEND, 32'd0);
    bus_read("rst2_enable", OFF_ENABLE, 32'd0);
    bus_read("rst2_mode", OFF_MODE, 32'd0);
    bus_read("rst2_status", OFF_STATUS, 32'd0);

    // Write held off by two HREADY-low cycles.
    addr_phase(OFF_ENABLE, 1'b1);
    tick(1);
    idle_bus();
    HREADY = 1'b0;
    HWDATA = 32'h3C;
    tick(1);
    check_eq("stall_hold1", HRDATA, 32'd0);
    tick(1);
    check_eq("stall_hold2", HRDATA, 32'd0);
    HREADY = 1'b1;
    tick(1);
    bus_read("stall_enable", OFF_ENABLE, 32'h3C);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ra = $urandom;
      rb = $urandom;
      HSEL    = (ra[1:0] != 2'b00);
      HWRITE  = ra[2];
      HTRANS  = ra[4:3];
      HREADY  = (ra[7:5] != 3'b000);
      HADDR   = {ra[31:5], (rb[0] ? {rb[3:1], 2'b00} : rb[8:4])};
      HWDATA  = $urandom;
      irq_in  = rb[16:9] & rb[24:17];
      HRESETn = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    idle_bus();
    HREADY  = 1'b1;
    HRESETn = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_irq_ctrl.md
# ahb_irq_ctrl

AHB-Lite slave that aggregates peripheral interrupt lines (timer_irq from the AHB timer, GPIO and future peripherals) into one registered interrupt request with a source ID. It sits directly downstream of the timer, consuming its timer_irq output. It shares the timer's AHB decode slot conventions: always ready, with the address phase registered for the data phase. It provides per-source enable, level/edge mode, software set and write-1-to-clear, so firmware can poll or service one vectored line.

## Interface
- N_SRC, 8: number of interrupt sources, 1..32; source 0 is the timer.
- HCLK  in  1  system clock; the only clock.
- HRESETn  in  1  reset, synchronous, active-low.
- HADDR  in  32  AHB address; bits [4:0] decoded.
- HWDATA  in  32  AHB write data, data phase.
- HTRANS  in  2  AHB transfer type; bit 1 marks a valid transfer.
- HWRITE  in  1  AHB write strobe.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready; the address phase is captured only when it is high.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied to 1.
- irq_in  in  N_SRC  raw interrupt lines, synchronous to HCLK.
- irq_out  out  1  registered: any pending and enabled source.
- irq_id  out  5  registered: lowest-index pending and enabled source; 0 when none.

## Operation
- Register map, word offsets on HADDR[4:0]:
  - 0x00 PEND: read-only.
  - 0x04 ENABLE: read/write.
  - 0x08 MODE: read/write; 1 = edge, 0 = level.
  - 0x0C CLEAR: write-only, write 1 to clear; reads 0.
  - 0x10 STATUS: read-only; {irq_out at bit 31, irq_id in [4:0]}.
  - 0x14 SWSET: write-only, write 1 to set; reads 0.
  - Other offsets read 0 and writes are ignored.
- Bits [31:N_SRC] of all registers read 0.
- Writes complete in the data phase: the captured address phase (last_HSEL & last_HWRITE & last_HTRANS[1]) is qualified, and HWDATA is taken the same cycle.
- Level-mode source i: pend[i] <= irq_in[i] every cycle. CLEAR and SWSET have no effect.
- Edge-mode source i:
  - pend[i] is set when irq_in[i]=1 and irq_prev[i]=0, or on an SWSET bit.
  - pend[i] is cleared by a CLEAR bit.
  - If set and clear occur in the same cycle, set wins.
- irq_prev <= irq_in every cycle.
- Pending bits latch regardless of ENABLE. ENABLE masks only irq_out and irq_id.
- Changing MODE from edge to level: pend takes the irq_in value at the next edge.
- Changing MODE from level to edge: pend holds its value until cleared.
- Priority: fixed, lowest index wins.

## Timing
- Reset values:
  - pend, enable, mode, irq_prev: 0.
  - irq_out: 0; irq_id: 0.
  - HRDATA reflects the reset registers.
- Capture registers (last_*) are not reset, only qualified. Reset beats any write in the same cycle.
- Edge k, irq_in first high: pend[i] is set at edge k.
- irq_out and irq_id update at edge k+1, so source-to-output latency is 2 edges from the first sampled-high cycle.
- CLEAR write in the data phase ending at edge k: pend drops at k, irq_out drops at k+1.
- Writes to ENABLE, MODE, CLEAR and SWSET in the data phase are visible to a read whose data phase starts the following cycle.
- HRDATA is combinational from last_HADDR and the current register contents.
- A read of PEND in the same cycle as an edge event returns the pre-edge value.
- With HREADY low, the capture registers hold; a stalled write occurs once.

## Structure
- Shared package ahb_irq_pkg holds:
  - register offset constants;
  - the ID width (5);
  - the maximum N_SRC (32).
- Sub-module irq_prio_enc: combinational, input N_SRC bits of pend & enable; outputs any and idx[4:0], lowest index wins. It is instantiated once, and its outputs are registered in ahb_irq_ctrl.
- The timer's timer_irq connects to irq_in[0] at SoC top.

## Test plan
- Reset, then read all offsets -> every read returns 0, and irq_out=0, irq_id=0.
- Level mode, ENABLE=0x01, irq_in[0] pulsed high for 3 cycles:
  - irq_out high for exactly 3 cycles, delayed 2 edges;
  - irq_id=0;
  - a CLEAR write of 0x01 mid-pulse has no effect.
- Edge mode on sources 2 and 5, ENABLE=0x24:
  - a 1-cycle pulse on both -> irq_out=1, irq_id=2;
  - write CLEAR=0x04 -> irq_id=5;
  - write CLEAR=0x20 -> irq_out=0 one edge after pend clears.
- Edge mode on source 3, a rising edge and a CLEAR=0x08 write in the same cycle -> PEND bit 3 stays 1 (set wins).
- ENABLE=0, SWSET=0x80 in edge mode:
  - PEND reads 0x80, irq_out=0;
  - then ENABLE=0x80 -> irq_out=1, irq_id=7, STATUS reads 0x8000_0007.
- HRESETn driven low while pend=0xFF and irq_out=1 -> at the next edge every register and irq_out/irq_id read 0.
- Write ENABLE with HREADY low for 2 cycles -> the value is written once and a read-back matches.
